// File: rtl/vx_avs_pkg.sv
// vx_avs_pkg
// Shared definitions for the Avalon-MM adapter:
//   AVS_BURST_SINGLE  burstcount value for single-beat transfers
//   credit_w()        width of a counter that must reach RD_QUEUE_SIZE inclusive
//   avs_rsp_t         read response bundle (data + tag) at the default widths
package vx_avs_pkg;

    localparam int AVS_BURST_SINGLE = 1;

    localparam int AVS_RSP_DATAW = 512;
    localparam int AVS_RSP_TAGW  = 8;

    typedef struct packed {
        logic [AVS_RSP_DATAW-1:0] data;
        logic [AVS_RSP_TAGW-1:0]  tag;
    } avs_rsp_t;

    // One extra bit so the counter can hold the full-queue value itself.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vx_avs_fifo.sv
// vx_avs_fifo
// Generic synchronous FIFO; head data read straight from the storage registers.
// Ports:
//   clk, reset        clock, synchronous active-high reset (pointers only)
//   i_push, i_data    write side; push ignored when full
//   i_pop             read side; pop ignored when empty
//   o_data            current head entry
//   o_full, o_empty   status flags
module vx_avs_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/vx_avs_adapter.sv
// vx_avs_adapter
// Converts beat-level valid/ready memory requests into single-beat Avalon-MM
// cycles and returns read data in order with the original tag attached.
// Reads are throttled by a credit counter so the response buffer can never
// overflow (Avalon readdata cannot be back-pressured). Writes are posted.
// Optional macro AVS_ADAPTER_PERF_EN adds perf_rd_count, perf_wr_count and
// perf_stall_cycles (32-bit wrapping counters).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_req_*             request channel from the width converter
//   mem_rsp_*             in-order read response channel
//   avs_*                 Avalon-MM master
module vx_avs_adapter
    import vx_avs_pkg::*;
#(
    parameter int AVS_DATAW     = 512,
    parameter int AVS_ADDRW     = 26,
    parameter int AVS_BYTEENW   = AVS_DATAW / 8,
    parameter int AVS_BURSTW    = 4,
    parameter int TAG_WIDTH     = 8,
    parameter int RD_QUEUE_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    input  logic                   mem_req_rw,
    input  logic [AVS_ADDRW-1:0]   mem_req_addr,
    input  logic [AVS_BYTEENW-1:0] mem_req_byteen,
    input  logic [AVS_DATAW-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]   mem_req_tag,
    output logic                   mem_req_ready,
    output logic                   mem_rsp_valid,
    output logic [AVS_DATAW-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
    input  logic                   mem_rsp_ready,
    output logic                   avs_read,
    output logic                   avs_write,
    output logic [AVS_ADDRW-1:0]   avs_address,
    output logic [AVS_DATAW-1:0]   avs_writedata,
    output logic [AVS_BYTEENW-1:0] avs_byteenable,
    output logic [AVS_BURSTW-1:0]  avs_burstcount,
    input  logic                   avs_waitrequest,
    input  logic                   avs_readdatavalid,
`ifdef AVS_ADAPTER_PERF_EN
    output logic [31:0]            perf_rd_count,
    output logic [31:0]            perf_wr_count,
    output logic [31:0]            perf_stall_cycles,
`endif
    input  logic [AVS_DATAW-1:0]   avs_readdata
);

    localparam int CW = credit_w(RD_QUEUE_SIZE);

    logic [CW-1:0] r_rd_credit_ctr;
    logic          w_credit_ok;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic          w_rsp_fire;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic          w_data_full;
    logic          w_data_empty;

    // Credits only fall on a response pop, never on a held read, so a
    // pending avs_read cannot be withdrawn by the credit check.
    assign w_credit_ok = (r_rd_credit_ctr < CW'(RD_QUEUE_SIZE));

    assign avs_write     = mem_req_valid & mem_req_rw & ~reset;
    assign avs_read      = mem_req_valid & ~mem_req_rw & w_credit_ok & ~reset;
    assign mem_req_ready = ~reset & ~avs_waitrequest & (mem_req_rw | w_credit_ok);

    assign avs_address    = mem_req_addr;
    assign avs_writedata  = mem_req_data;
    assign avs_byteenable = mem_req_byteen;
    assign avs_burstcount = AVS_BURSTW'(AVS_BURST_SINGLE);

    assign w_rd_fire  = avs_read & ~avs_waitrequest;
    assign w_wr_fire  = avs_write & ~avs_waitrequest;
    assign w_rsp_fire = mem_rsp_valid & mem_rsp_ready;

    assign mem_rsp_valid = ~w_data_empty;

    vx_avs_fifo #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (RD_QUEUE_SIZE)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rd_fire),
        .i_pop   (w_rsp_fire),
        .i_data  (mem_req_tag),
        .o_data  (mem_rsp_tag),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    vx_avs_fifo #(
        .WIDTH (AVS_DATAW),
        .DEPTH (RD_QUEUE_SIZE)
    ) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (avs_readdatavalid),
        .i_pop   (w_rsp_fire),
        .i_data  (avs_readdata),
        .o_data  (mem_rsp_data),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_credit_ctr <= '0;
        end else if (w_rd_fire && !w_rsp_fire) begin
            r_rd_credit_ctr <= r_rd_credit_ctr + {{(CW-1){1'b0}}, 1'b1};
        end else if (!w_rd_fire && w_rsp_fire) begin
            r_rd_credit_ctr <= r_rd_credit_ctr - {{(CW-1){1'b0}}, 1'b1};
        end
    end

`ifdef AVS_ADAPTER_PERF_EN
    logic [31:0] r_perf_rd;
    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_rd    <= '0;
            r_perf_wr    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_rd_fire) r_perf_rd <= r_perf_rd + 32'd1;
            if (w_wr_fire) r_perf_wr <= r_perf_wr + 32'd1;
            if (mem_req_valid && !mem_req_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_rd_count     = r_perf_rd;
    assign perf_wr_count     = r_perf_wr;
    assign perf_stall_cycles = r_perf_stall;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_data_no_overflow: assert (!(avs_readdatavalid && w_data_full));
            a_tag_no_overflow:  assert (!(w_rd_fire && w_tag_full));
            a_tag_with_data:    assert (!(!w_data_empty && w_tag_empty));
        end
    end

endmodule

// File: tb/tb_vx_avs_adapter.sv
module tb_vx_avs_adapter;
    import vx_avs_pkg::*;

    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int BEW = 64;
    localparam int BW  = 4;
    localparam int TW  = 8;
    localparam int QS  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AW-1:0]  mem_req_addr;
    logic [BEW-1:0] mem_req_byteen;
    logic [DW-1:0]  mem_req_data;
    logic [TW-1:0]  mem_req_tag;
    logic           mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0]  mem_rsp_data;
    logic [TW-1:0]  mem_rsp_tag;
    logic           avs_read, avs_write, avs_waitrequest, avs_readdatavalid;
    logic [AW-1:0]  avs_address;
    logic [DW-1:0]  avs_writedata, avs_readdata;
    logic [BEW-1:0] avs_byteenable;
    logic [BW-1:0]  avs_burstcount;
`ifdef AVS_ADAPTER_PERF_EN
    logic [31:0]    perf_rd_count, perf_wr_count, perf_stall_cycles;
    logic [31:0]    m_prd, m_pwr, m_pst;
`endif

    vx_avs_adapter dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_byteen    (mem_req_byteen),
        .mem_req_data      (mem_req_data),
        .mem_req_tag       (mem_req_tag),
        .mem_req_ready     (mem_req_ready),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .mem_rsp_tag       (mem_rsp_tag),
        .mem_rsp_ready     (mem_rsp_ready),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_address       (avs_address),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdatavalid (avs_readdatavalid),
`ifdef AVS_ADAPTER_PERF_EN
        .perf_rd_count     (perf_rd_count),
        .perf_wr_count     (perf_wr_count),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .avs_readdata      (avs_readdata)
    );

    always #5 clk = ~clk;

    // Reference model: reads in issue order with the data the slave will return,
    // slave return schedule, outstanding-read count, responses buffered in DUT.
    typedef struct { logic [DW-1:0] data; int due; } slv_t;
    avs_rsp_t exp_q[$];
    slv_t     slv_q[$];
    int m_credit, m_data_cnt, cyc;
    int n_checks, n_fail;
    int wait_pct, rdy_pct, force_wait, lat_min, lat_max;
    bit slave_en, m_acc;
    int obs_acc, obs_stall;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit exp_ok, exp_rd, exp_wr, exp_rdy, exp_rv, rd_fire, wr_fire, rsp_fire, coinc;
        int credit_before;
        avs_rsp_t e;
        if (force_wait > 0) begin
            avs_waitrequest = 1'b1;
            force_wait--;
        end else begin
            avs_waitrequest = ($urandom_range(99) < wait_pct);
        end
        mem_rsp_ready     = ($urandom_range(99) < rdy_pct);
        avs_readdatavalid = 1'b0;
        avs_readdata      = '0;
        if (!reset && slave_en && slv_q.size() > 0 && slv_q[0].due <= cyc) begin
            avs_readdatavalid = 1'b1;
            avs_readdata      = slv_q[0].data;
            void'(slv_q.pop_front());
        end
        #1;
        exp_ok  = (m_credit < QS);
        exp_rd  = mem_req_valid && !mem_req_rw && exp_ok && !reset;
        exp_wr  = mem_req_valid && mem_req_rw && !reset;
        exp_rdy = !reset && !avs_waitrequest && (mem_req_rw || exp_ok);
        exp_rv  = (m_data_cnt > 0);
        check_val("avs_read", DW'(avs_read), DW'(exp_rd));
        check_val("avs_write", DW'(avs_write), DW'(exp_wr));
        check_val("req_ready", DW'(mem_req_ready), DW'(exp_rdy));
        check_val("rsp_valid", DW'(mem_rsp_valid), DW'(exp_rv));
        check_val("avs_addr", DW'(avs_address), DW'(mem_req_addr));
        check_val("avs_wdata", avs_writedata, mem_req_data);
        check_val("avs_byteen", DW'(avs_byteenable), DW'(mem_req_byteen));
        check_val("burstcount", DW'(avs_burstcount), DW'(1));
        check_val("credit", DW'(dut.r_rd_credit_ctr), DW'(m_credit));
        if (exp_rv && exp_q.size() > 0) begin
            check_val("rsp_data", mem_rsp_data, exp_q[0].data);
            check_val("rsp_tag", DW'(mem_rsp_tag), DW'(exp_q[0].tag));
        end
        if (mem_req_valid && mem_req_ready) obs_acc++;
        if (mem_req_valid && !mem_req_ready) obs_stall++;
        m_acc    = mem_req_valid && exp_rdy;
        rd_fire  = exp_rd && !avs_waitrequest;
        wr_fire  = exp_wr && !avs_waitrequest;
        rsp_fire = exp_rv && mem_rsp_ready;
        coinc    = 1'b0;
        credit_before = m_credit;
        if (reset) begin
            exp_q.delete();
            slv_q.delete();
            m_credit   = 0;
            m_data_cnt = 0;
`ifdef AVS_ADAPTER_PERF_EN
            m_prd = 0; m_pwr = 0; m_pst = 0;
`endif
        end else begin
            coinc = rd_fire && rsp_fire;
            if (rd_fire) begin
                e.data = rand_data();
                e.tag  = mem_req_tag;
                exp_q.push_back(e);
                slv_q.push_back('{data: e.data, due: cyc + $urandom_range(lat_max, lat_min)});
                m_credit++;
            end
            if (rsp_fire) begin
                void'(exp_q.pop_front());
                m_data_cnt--;
                m_credit--;
            end
            if (avs_readdatavalid) m_data_cnt++;
`ifdef AVS_ADAPTER_PERF_EN
            if (rd_fire) m_prd++;
            if (wr_fire) m_pwr++;
            if (mem_req_valid && !exp_rdy) m_pst++;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
        if (coinc) check_val("credit_same_cycle", DW'(dut.r_rd_credit_ctr), DW'(credit_before));
    endtask

    task automatic wait_acc(input string what);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = m_acc;
        end
        check_val({what, "_accepted"}, DW'(got), DW'(1));
    endtask

    task automatic drive_req(input bit rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_tag    = tag;
        mem_req_data   = rand_data();
        mem_req_byteen = {$urandom(), $urandom()};
    endtask

    task automatic issue(input bit rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        drive_req(rw, addr, tag);
        wait_acc(rw ? "wr" : "rd");
        mem_req_valid = 1'b0;
    endtask

    task automatic drain(input string what);
        slave_en = 1'b1;
        for (int i = 0; i < 1000 && (exp_q.size() > 0 || m_data_cnt > 0); i++) step();
        check_val({what, "_drained"}, DW'(exp_q.size()), DW'(0));
        step();
        check_val({what, "_credit_idle"}, DW'(dut.r_rd_credit_ctr), DW'(0));
    endtask

    int a0, s0;

    initial begin
        reset = 1'b1;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0;
        mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0;
        mem_rsp_ready = 1'b0; avs_waitrequest = 1'b0;
        avs_readdatavalid = 1'b0; avs_readdata = '0;
        wait_pct = 0; rdy_pct = 100; force_wait = 0; slave_en = 1'b1;
        lat_min = 1; lat_max = 1;
        @(posedge clk); #1;
        drive_req(1'b0, 26'h3, 8'h1);  // request held during reset: must not be accepted
        step(); step();
        mem_req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_val("rst_rsp_valid", DW'(mem_rsp_valid), DW'(0));
        check_val("rst_credit", DW'(dut.r_rd_credit_ctr), DW'(0));

        // single read, slave answers 3 cycles after issue
        lat_min = 3; lat_max = 3;
        issue(1'b0, 26'h10, 8'h5A);
        drain("single");

        // write stalled by waitrequest for 4 cycles
        a0 = obs_acc; s0 = obs_stall;
        drive_req(1'b1, 26'h2A5, 8'h00);
        force_wait = 4;
        wait_acc("wr_hold");
        mem_req_valid = 1'b0;
        check_val("wr_hold_accepts", DW'(obs_acc - a0), DW'(1));
        check_val("wr_hold_stalls", DW'(obs_stall - s0), DW'(4));
        step();

        // credit exhaustion
        slave_en = 1'b0; rdy_pct = 0;
        for (int i = 0; i < QS; i++) issue(1'b0, AW'(32'h100 + i), TW'(i));
        check_val("credit_full", DW'(dut.r_rd_credit_ctr), DW'(QS));
        a0 = obs_acc;
        drive_req(1'b0, 26'h200, 8'h11);
        step(); step(); step();
        #1;
        check_val("rd17_avs_read", DW'(avs_read), DW'(0));
        check_val("rd17_ready", DW'(mem_req_ready), DW'(0));
        check_val("rd17_no_accept", DW'(obs_acc - a0), DW'(0));
        slave_en = 1'b1; lat_min = 1; lat_max = 3; rdy_pct = 100;
        wait_acc("rd17");
        mem_req_valid = 1'b0;
        drain("exhaust");

        // ordering with random response back-pressure
        lat_min = 1; lat_max = 5; rdy_pct = 50;
        for (int i = 0; i < 8; i++) issue(1'b0, AW'($urandom()), TW'(i));
        drain("order");

        // mixed traffic
        wait_pct = 25; rdy_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 60; i++) issue(i[0], AW'($urandom()), TW'($urandom()));
        drain("mixed");

`ifdef AVS_ADAPTER_PERF_EN
        check_val("perf_rd", DW'(perf_rd_count), DW'(m_prd));
        check_val("perf_wr", DW'(perf_wr_count), DW'(m_pwr));
        check_val("perf_stall", DW'(perf_stall_cycles), DW'(m_pst));
`endif

        // reset with reads outstanding and some data buffered
        wait_pct = 0; rdy_pct = 0; lat_min = 1; lat_max = 2;
        for (int i = 0; i < 5; i++) issue(1'b0, AW'(32'h300 + i), TW'(8'h40 + i));
        step(); step(); step();
        check_val("pre_rst_credit", DW'(dut.r_rd_credit_ctr), DW'(5));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("midrst_rsp_valid", DW'(mem_rsp_valid), DW'(0));
        check_val("midrst_credit", DW'(dut.r_rd_credit_ctr), DW'(0));
`ifdef AVS_ADAPTER_PERF_EN
        check_val("midrst_perf_rd", DW'(perf_rd_count), DW'(0));
        check_val("midrst_perf_wr", DW'(perf_wr_count), DW'(0));
        check_val("midrst_perf_stall", DW'(perf_stall_cycles), DW'(0));
`endif
        rdy_pct = 100;
        issue(1'b0, 26'h77, 8'hC3);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
